// File: rtl/mem_align_splitter.sv
// Splits misaligned HALF/WORD accesses into byte beats and merges load bytes;
// aligned accesses pass straight through to the memory stage.
module mem_align_splitter #(
  parameter int XLEN           = 32,
  parameter bit ALLOW_MISALIGN = 1'b1
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            flush_i,
  input  logic            ex_valid_i,
  input  logic [XLEN-1:0] ex_addr_i,
  input  logic            ex_rw_i,
  input  logic [1:0]      ex_rw_size_i,
  input  logic [XLEN-1:0] ex_wdata_i,
  input  logic            ex_ld_sign_i,
  output logic            mem_valid_o,
  output logic [XLEN-1:0] mem_addr_o,
  output logic            mem_rw_o,
  output logic [1:0]      mem_rw_size_o,
  output logic [XLEN-1:0] mem_wdata_o,
  output logic            mem_ld_sign_o,
  input  logic            mem_done_i,
  input  logic [XLEN-1:0] mem_rdata_i,
  output logic            res_valid_o,
  output logic [XLEN-1:0] res_rdata_o,
  output logic            stall_o,
  output logic            fault_o
);

  localparam logic [1:0] SizeByte = 2'b00;
  localparam logic [1:0] SizeHalf = 2'b01;
  localparam logic [1:0] SizeWord = 2'b10;

  typedef enum logic [1:0] {IDLE, SPLIT, DONE} state_t;

  state_t          state_q, state_d;
  logic [1:0]      k_q, k_d;
  logic [1:0]      lastK_q, lastK_d;
  logic [XLEN-1:0] addr_q, addr_d;
  logic [XLEN-1:0] wdata_q, wdata_d;
  logic            rw_q, rw_d;
  logic            sign_q, sign_d;
  logic            half_q, half_d;
  logic [XLEN-1:0] merge_q, merge_d;
  logic            misaligned;

  assign misaligned = ((ex_rw_size_i == SizeHalf) && ex_addr_i[0]) ||
                      ((ex_rw_size_i == SizeWord) && (ex_addr_i[1:0] != 2'b00));

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      k_q     <= 2'd0;
      lastK_q <= 2'd0;
      addr_q  <= '0;
      wdata_q <= '0;
      rw_q    <= 1'b0;
      sign_q  <= 1'b0;
      half_q  <= 1'b0;
      merge_q <= '0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      lastK_q <= lastK_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rw_q    <= rw_d;
      sign_q  <= sign_d;
      half_q  <= half_d;
      merge_q <= merge_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    k_d           = k_q;
    lastK_d       = lastK_q;
    addr_d        = addr_q;
    wdata_d       = wdata_q;
    rw_d          = rw_q;
    sign_d        = sign_q;
    half_d        = half_q;
    merge_d       = merge_q;
    mem_valid_o   = 1'b0;
    mem_addr_o    = '0;
    mem_rw_o      = 1'b0;
    mem_rw_size_o = 2'b00;
    mem_wdata_o   = '0;
    mem_ld_sign_o = 1'b0;
    res_valid_o   = 1'b0;
    res_rdata_o   = '0;
    stall_o       = 1'b0;
    fault_o       = 1'b0;

    case (state_q)
      IDLE: begin
        if (ex_valid_i) begin
          if (!misaligned) begin
            mem_valid_o   = 1'b1;
            mem_addr_o    = ex_addr_i;
            mem_rw_o      = ex_rw_i;
            mem_rw_size_o = ex_rw_size_i;
            mem_wdata_o   = ex_wdata_i;
            mem_ld_sign_o = ex_ld_sign_i;
            res_valid_o   = mem_done_i;
            res_rdata_o   = mem_rdata_i;
            stall_o       = ~mem_done_i;
          end else if (ALLOW_MISALIGN) begin
            state_d = SPLIT;
            k_d     = 2'd0;
            lastK_d = (ex_rw_size_i == SizeHalf) ? 2'd1 : 2'd3;
            addr_d  = ex_addr_i;
            wdata_d = ex_wdata_i;
            rw_d    = ex_rw_i;
            sign_d  = ex_ld_sign_i;
            half_d  = (ex_rw_size_i == SizeHalf);
            merge_d = '0;
            stall_o = 1'b1;
          end else begin
            fault_o = 1'b1;
          end
        end
      end
      SPLIT: begin
        mem_valid_o        = 1'b1;
        mem_addr_o         = addr_q + XLEN'(k_q);
        mem_rw_o           = rw_q;
        mem_rw_size_o      = SizeByte;
        mem_wdata_o[7:0]   = wdata_q[8*k_q +: 8];
        stall_o            = 1'b1;
        if (mem_done_i) begin
          merge_d[8*k_q +: 8] = mem_rdata_i[7:0];
          k_d                 = k_q + 2'd1;
          if (k_q == lastK_q) begin
            state_d = DONE;
          end
        end
      end
      DONE: begin
        res_valid_o = 1'b1;
        if (!rw_q) begin
          res_rdata_o = half_q ? {{(XLEN-16){sign_q & merge_q[15]}}, merge_q[15:0]}
                               : merge_q;
        end
        state_d = IDLE;
        k_d     = 2'd0;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Flush (and reset) wins over a completing beat and silences every output.
    if (flush_i || rst_i) begin
      state_d       = IDLE;
      k_d           = 2'd0;
      merge_d       = '0;
      mem_valid_o   = 1'b0;
      mem_addr_o    = '0;
      mem_rw_o      = 1'b0;
      mem_rw_size_o = 2'b00;
      mem_wdata_o   = '0;
      mem_ld_sign_o = 1'b0;
      res_valid_o   = 1'b0;
      res_rdata_o   = '0;
      stall_o       = 1'b0;
      fault_o       = 1'b0;
    end
  end

endmodule

// File: tb/tb_mem_align_splitter.sv
// Directed bench for mem_align_splitter: table-driven pass-through vectors plus
// hand-written split, wrap, flush and fault sequences.
module tb_mem_align_splitter;

  localparam logic [1:0] BYTE = 2'b00;
  localparam logic [1:0] HALF = 2'b01;
  localparam logic [1:0] WORD = 2'b10;
  localparam logic [1:0] NOSZ = 2'b11;

  logic        clock = 1'b0;
  logic        reset;
  logic        flush;
  logic        exValid, nfValid;
  logic [31:0] exAddr;
  logic        exRw;
  logic [1:0]  exSize;
  logic [31:0] exWdata;
  logic        exSign;
  logic        memDone;
  logic [31:0] memRdata;

  logic        memValid, memRw, memLdSign, resValid, stall, fault;
  logic [31:0] memAddr, memWdata, resRdata;
  logic [1:0]  memSize;

  logic        nfMemValid, nfMemRw, nfMemLdSign, nfResValid, nfStall, nfFault;
  logic [31:0] nfMemAddr, nfMemWdata, nfResRdata;
  logic [1:0]  nfMemSize;

  int checkCount = 0;
  int passCount  = 0;
  int resCount;

  always #5 clock = ~clock;

  mem_align_splitter #(.XLEN(32), .ALLOW_MISALIGN(1'b1)) dut (
    .clk_i(clock), .rst_i(reset), .flush_i(flush),
    .ex_valid_i(exValid), .ex_addr_i(exAddr), .ex_rw_i(exRw),
    .ex_rw_size_i(exSize), .ex_wdata_i(exWdata), .ex_ld_sign_i(exSign),
    .mem_valid_o(memValid), .mem_addr_o(memAddr), .mem_rw_o(memRw),
    .mem_rw_size_o(memSize), .mem_wdata_o(memWdata), .mem_ld_sign_o(memLdSign),
    .mem_done_i(memDone), .mem_rdata_i(memRdata),
    .res_valid_o(resValid), .res_rdata_o(resRdata), .stall_o(stall), .fault_o(fault)
  );

  mem_align_splitter #(.XLEN(32), .ALLOW_MISALIGN(1'b0)) dutNoSplit (
    .clk_i(clock), .rst_i(reset), .flush_i(flush),
    .ex_valid_i(nfValid), .ex_addr_i(exAddr), .ex_rw_i(exRw),
    .ex_rw_size_i(exSize), .ex_wdata_i(exWdata), .ex_ld_sign_i(exSign),
    .mem_valid_o(nfMemValid), .mem_addr_o(nfMemAddr), .mem_rw_o(nfMemRw),
    .mem_rw_size_o(nfMemSize), .mem_wdata_o(nfMemWdata), .mem_ld_sign_o(nfMemLdSign),
    .mem_done_i(memDone), .mem_rdata_i(memRdata),
    .res_valid_o(nfResValid), .res_rdata_o(nfResRdata), .stall_o(nfStall), .fault_o(nfFault)
  );

  typedef struct {
    logic        valid;
    logic [31:0] addr;
    logic        rw;
    logic [1:0]  size;
    logic [31:0] wdata;
    logic        sign;
    logic        done;
    logic [31:0] rdata;
    logic        expMemValid;
    logic [31:0] expAddr;
    logic [1:0]  expSize;
    logic        expStall;
    logic        expResValid;
    logic [31:0] expResRdata;
  } vec_t;

  vec_t vecs[7];

  task automatic applyStimulus(input logic valid, input logic [31:0] addr, input logic rw,
                               input logic [1:0] size, input logic [31:0] wdata,
                               input logic sign, input logic done, input logic [31:0] rdata);
    exValid  = valid;
    exAddr   = addr;
    exRw     = rw;
    exSize   = size;
    exWdata  = wdata;
    exSign   = sign;
    memDone  = done;
    memRdata = rdata;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checkCount++;
    if (actual !== expected)
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    else
      passCount++;
  endtask

  task automatic tick;
    @(posedge clock);
    @(negedge clock);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [31:0] wrapAddr[4];
    logic [7:0]  swBytes[4];
    logic [7:0]  lwBytes[4];

    vecs[0] = '{1'b0, 32'h0000_0000, 1'b0, BYTE, 32'h0, 1'b0, 1'b1, 32'h0000_0055,
                1'b0, 32'h0, BYTE, 1'b0, 1'b0, 32'h0};
    vecs[1] = '{1'b1, 32'h0000_0100, 1'b0, WORD, 32'h0, 1'b0, 1'b0, 32'h0,
                1'b1, 32'h0000_0100, WORD, 1'b1, 1'b0, 32'h0};
    vecs[2] = '{1'b1, 32'h0000_0100, 1'b0, WORD, 32'h0, 1'b0, 1'b1, 32'hCAFE_F00D,
                1'b1, 32'h0000_0100, WORD, 1'b0, 1'b1, 32'hCAFE_F00D};
    vecs[3] = '{1'b1, 32'h0000_0102, 1'b1, HALF, 32'h0000_BEEF, 1'b0, 1'b1, 32'h0,
                1'b1, 32'h0000_0102, HALF, 1'b0, 1'b1, 32'h0};
    vecs[4] = '{1'b1, 32'h0000_0003, 1'b0, BYTE, 32'h0, 1'b1, 1'b0, 32'h0,
                1'b1, 32'h0000_0003, BYTE, 1'b1, 1'b0, 32'h0};
    vecs[5] = '{1'b1, 32'h0000_0007, 1'b0, NOSZ, 32'h0, 1'b0, 1'b0, 32'h0,
                1'b1, 32'h0000_0007, NOSZ, 1'b1, 1'b0, 32'h0};
    vecs[6] = '{1'b1, 32'h0000_0106, 1'b0, HALF, 32'h0, 1'b1, 1'b1, 32'h0000_1234,
                1'b1, 32'h0000_0106, HALF, 1'b0, 1'b1, 32'h0000_1234};

    wrapAddr = '{32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001};
    swBytes  = '{8'h44, 8'h33, 8'h22, 8'h11};
    lwBytes  = '{8'h01, 8'h02, 8'h03, 8'h04};

    reset   = 1'b1;
    flush   = 1'b0;
    nfValid = 1'b0;
    applyStimulus(0, 0, 0, BYTE, 0, 0, 0, 0);
    tick;
    tick;
    checkOutput("rst_memValid", {31'b0, memValid}, 32'd0);
    checkOutput("rst_stall", {31'b0, stall}, 32'd0);
    reset = 1'b0;
    tick;
    checkOutput("idle_memValid", {31'b0, memValid}, 32'd0);
    checkOutput("idle_resValid", {31'b0, resValid}, 32'd0);
    checkOutput("idle_resRdata", resRdata, 32'd0);

    for (int i = 0; i < 7; i++) begin
      applyStimulus(vecs[i].valid, vecs[i].addr, vecs[i].rw, vecs[i].size,
                    vecs[i].wdata, vecs[i].sign, vecs[i].done, vecs[i].rdata);
      #1;
      checkOutput($sformatf("vec%0d_memValid", i), {31'b0, memValid}, {31'b0, vecs[i].expMemValid});
      checkOutput($sformatf("vec%0d_memAddr", i), memAddr, vecs[i].expAddr);
      checkOutput($sformatf("vec%0d_memSize", i), {30'b0, memSize}, {30'b0, vecs[i].expSize});
      checkOutput($sformatf("vec%0d_stall", i), {31'b0, stall}, {31'b0, vecs[i].expStall});
      checkOutput($sformatf("vec%0d_resValid", i), {31'b0, resValid}, {31'b0, vecs[i].expResValid});
      checkOutput($sformatf("vec%0d_resRdata", i), resRdata, vecs[i].expResRdata);
      tick;
    end
    applyStimulus(0, 0, 0, BYTE, 0, 0, 0, 0);
    tick;

    // Aligned LW with a three-cycle memory latency
    for (int c = 0; c < 3; c++) begin
      applyStimulus(1, 32'h100, 0, WORD, 0, 0, 0, 0);
      #1;
      checkOutput($sformatf("lw_wait%0d_stall", c), {31'b0, stall}, 32'd1);
      checkOutput($sformatf("lw_wait%0d_resValid", c), {31'b0, resValid}, 32'd0);
      tick;
    end
    applyStimulus(1, 32'h100, 0, WORD, 0, 0, 1, 32'hDEAD_BEEF);
    #1;
    checkOutput("lw_done_resValid", {31'b0, resValid}, 32'd1);
    checkOutput("lw_done_resRdata", resRdata, 32'hDEAD_BEEF);
    checkOutput("lw_done_stall", {31'b0, stall}, 32'd0);
    tick;
    applyStimulus(0, 0, 0, BYTE, 0, 0, 0, 0);
    #1;
    checkOutput("lw_after_resValid", {31'b0, resValid}, 32'd0);
    tick;

    // Misaligned signed LH @0x103 with one wait cycle on the first beat
    applyStimulus(1, 32'h103, 0, HALF, 0, 1, 0, 0);
    #1;
    checkOutput("lh_cap_stall", {31'b0, stall}, 32'd1);
    checkOutput("lh_cap_memValid", {31'b0, memValid}, 32'd0);
    tick;
    checkOutput("lh_b0wait_memValid", {31'b0, memValid}, 32'd1);
    checkOutput("lh_b0wait_addr", memAddr, 32'h103);
    checkOutput("lh_b0wait_size", {30'b0, memSize}, {30'b0, BYTE});
    checkOutput("lh_b0wait_ldSign", {31'b0, memLdSign}, 32'd0);
    checkOutput("lh_b0wait_stall", {31'b0, stall}, 32'd1);
    tick;
    applyStimulus(1, 32'h103, 0, HALF, 0, 1, 1, 32'hABCD_EF80);
    #1;
    checkOutput("lh_b0_addr", memAddr, 32'h103);
    tick;
    applyStimulus(1, 32'h103, 0, HALF, 0, 1, 1, 32'h1234_56FF);
    #1;
    checkOutput("lh_b1_addr", memAddr, 32'h104);
    checkOutput("lh_b1_stall", {31'b0, stall}, 32'd1);
    tick;
    applyStimulus(1, 32'h103, 0, HALF, 0, 1, 0, 0);
    #1;
    checkOutput("lh_done_resValid", {31'b0, resValid}, 32'd1);
    checkOutput("lh_done_resRdata", resRdata, 32'hFFFF_FF80);
    checkOutput("lh_done_stall", {31'b0, stall}, 32'd0);
    checkOutput("lh_done_memValid", {31'b0, memValid}, 32'd0);
    tick;
    applyStimulus(0, 0, 0, BYTE, 0, 0, 0, 0);
    #1;
    checkOutput("lh_after_resValid", {31'b0, resValid}, 32'd0);
    tick;

    // Misaligned SW @0x201 split into four byte stores
    resCount = 0;
    applyStimulus(1, 32'h201, 1, WORD, 32'h1122_3344, 0, 0, 0);
    #1;
    checkOutput("sw_cap_stall", {31'b0, stall}, 32'd1);
    resCount += int'(resValid);
    tick;
    for (int b = 0; b < 4; b++) begin
      applyStimulus(1, 32'h201, 1, WORD, 32'h1122_3344, 0, 1, 0);
      #1;
      checkOutput($sformatf("sw_b%0d_addr", b), memAddr, 32'h201 + b);
      checkOutput($sformatf("sw_b%0d_wdata", b), memWdata, {24'b0, swBytes[b]});
      checkOutput($sformatf("sw_b%0d_rw", b), {31'b0, memRw}, 32'd1);
      checkOutput($sformatf("sw_b%0d_stall", b), {31'b0, stall}, 32'd1);
      resCount += int'(resValid);
      tick;
    end
    applyStimulus(1, 32'h201, 1, WORD, 32'h1122_3344, 0, 0, 0);
    #1;
    checkOutput("sw_done_resValid", {31'b0, resValid}, 32'd1);
    checkOutput("sw_done_resRdata", resRdata, 32'd0);
    resCount += int'(resValid);
    tick;
    applyStimulus(0, 0, 0, BYTE, 0, 0, 0, 0);
    #1;
    resCount += int'(resValid);
    checkOutput("sw_resValid_count", resCount, 32'd1);
    tick;

    // Misaligned unsigned LW wrapping past the top of the address space
    applyStimulus(1, 32'hFFFF_FFFE, 0, WORD, 0, 0, 0, 0);
    tick;
    for (int b = 0; b < 4; b++) begin
      applyStimulus(1, 32'hFFFF_FFFE, 0, WORD, 0, 0, 1, {24'hA5A5A5, lwBytes[b]});
      #1;
      checkOutput($sformatf("wrap_b%0d_addr", b), memAddr, wrapAddr[b]);
      tick;
    end
    applyStimulus(1, 32'hFFFF_FFFE, 0, WORD, 0, 0, 0, 0);
    #1;
    checkOutput("wrap_done_resValid", {31'b0, resValid}, 32'd1);
    checkOutput("wrap_done_resRdata", resRdata, 32'h0403_0201);
    tick;
    applyStimulus(0, 0, 0, BYTE, 0, 0, 0, 0);
    tick;

    // Flush during the second beat of a misaligned LW
    applyStimulus(1, 32'h301, 0, WORD, 0, 0, 0, 0);
    tick;
    applyStimulus(1, 32'h301, 0, WORD, 0, 0, 1, 32'h11);
    tick;
    applyStimulus(1, 32'h301, 0, WORD, 0, 0, 1, 32'h22);
    flush = 1'b1;
    tick;
    flush = 1'b0;
    applyStimulus(0, 0, 0, BYTE, 0, 0, 0, 0);
    #1;
    checkOutput("flush_memValid", {31'b0, memValid}, 32'd0);
    checkOutput("flush_stall", {31'b0, stall}, 32'd0);
    checkOutput("flush_resValid", {31'b0, resValid}, 32'd0);
    checkOutput("flush_memAddr", memAddr, 32'd0);
    tick;
    for (int c = 0; c < 3; c++) begin
      checkOutput($sformatf("flush_quiet%0d_resValid", c), {31'b0, resValid}, 32'd0);
      checkOutput($sformatf("flush_quiet%0d_memValid", c), {31'b0, memValid}, 32'd0);
      tick;
    end
    applyStimulus(1, 32'h305, 0, BYTE, 0, 1, 1, 32'h0000_00AB);
    #1;
    checkOutput("lb_memAddr", memAddr, 32'h305);
    checkOutput("lb_memSize", {30'b0, memSize}, {30'b0, BYTE});
    checkOutput("lb_ldSign", {31'b0, memLdSign}, 32'd1);
    checkOutput("lb_resValid", {31'b0, resValid}, 32'd1);
    checkOutput("lb_resRdata", resRdata, 32'h0000_00AB);
    tick;
    applyStimulus(0, 0, 0, BYTE, 0, 0, 0, 0);
    tick;

    // Splitting disabled: misaligned LH faults, aligned LH still passes through
    nfValid = 1'b1;
    applyStimulus(0, 32'h11, 0, HALF, 0, 0, 0, 0);
    #1;
    checkOutput("nf_fault", {31'b0, nfFault}, 32'd1);
    checkOutput("nf_memValid", {31'b0, nfMemValid}, 32'd0);
    checkOutput("nf_stall", {31'b0, nfStall}, 32'd0);
    checkOutput("nf_resValid", {31'b0, nfResValid}, 32'd0);
    tick;
    nfValid = 1'b0;
    #1;
    checkOutput("nf_after_fault", {31'b0, nfFault}, 32'd0);
    checkOutput("nf_after_memValid", {31'b0, nfMemValid}, 32'd0);
    tick;
    nfValid = 1'b1;
    applyStimulus(0, 32'h12, 0, HALF, 0, 0, 0, 0);
    #1;
    checkOutput("nf_aligned_memValid", {31'b0, nfMemValid}, 32'd1);
    checkOutput("nf_aligned_fault", {31'b0, nfFault}, 32'd0);
    tick;
    nfValid = 1'b0;
    tick;

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
